// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front-end.
// Holds the FSM state encoding, the two-bit command codes carried at the top
// of each frame, and the default data/frame widths.
package spi_pkg;

   localparam int SPI_DATA_W = 8;
   localparam int FRAME_W    = SPI_DATA_W + 2;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CHK_CMD   = 3'd1;
   localparam logic [2:0] ST_WRITE     = 3'd2;
   localparam logic [2:0] ST_READ_ADD  = 3'd3;
   localparam logic [2:0] ST_READ_DATA = 3'd4;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_piso_shift.sv
// Parallel-in serial-out register that drives MISO.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   i_load     : capture i_data; its MSB appears on o_bit right away
//   i_clear    : abandon any transfer and force o_bit low
//   i_data     : byte to send
//   o_bit      : registered serial output, MSB first, low when idle
//   o_done     : high for one cycle once the LSB has been presented
module spi_piso_shift #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_bit,
   output logic              o_done
);

   localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

   logic [DATA_W-1:0] r_sreg;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_active;
   logic              r_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sreg   <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_bit    <= 1'b0;
      end else if (i_clear) begin
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_bit    <= 1'b0;
      end else if (i_load) begin
         // MSB goes straight to the output flop; the rest waits in r_sreg
         r_sreg   <= {i_data[DATA_W-2:0], 1'b0};
         r_bit    <= i_data[DATA_W-1];
         r_cnt    <= CNT_W'(DATA_W - 1);
         r_active <= 1'b1;
      end else if (r_active) begin
         if (r_cnt != '0) begin
            r_bit  <= r_sreg[DATA_W-1];
            r_sreg <= {r_sreg[DATA_W-2:0], 1'b0};
            r_cnt  <= r_cnt - 1'b1;
         end else begin
            r_bit    <= 1'b0;
            r_active <= 1'b0;
         end
      end
   end

   assign o_bit  = r_bit;
   assign o_done = r_active && (r_cnt == '0);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises {cmd, payload} frames from MOSI for the
// RAM and, on a read-data command, serialises the RAM's reply on MISO.
// Ports:
//   clk, rst_n         : system clock, async active-low reset
//   ss_n, mosi         : slave select (active low) and serial input, clk-synchronous
//   miso               : registered serial output
//   rx_data, rx_valid  : completed frame and its one-cycle strobe
//   tx_data, tx_valid  : read data returned by the RAM
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for ss_n low
// CHK_CMD    | sample frame bit 9, choose write or read path
// WRITE      | receive rest of a write frame, then hold
// READ_ADD   | receive read-address (or unmatched read) frame, then hold
// READ_DATA  | receive frame, wait for tx_valid, shift byte out on MISO
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ss_n,
   input  logic                mosi,
   output logic                miso,
   output logic [DATA_W+1:0]   rx_data,
   output logic                rx_valid,
   input  logic [DATA_W-1:0]   tx_data,
   input  logic                tx_valid
);

   localparam int LP_FRAME_W = DATA_W + 2;
   localparam int CNT_W      = $clog2(LP_FRAME_W);

   logic [2:0]            r_state;
   logic [LP_FRAME_W-1:0] r_shift;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic                  r_rx_seen;
   logic                  r_tx_started;
   logic                  r_rd_addr_done;
   logic [LP_FRAME_W-1:0] r_rx_data;
   logic                  r_rx_valid;

   logic w_abort;
   logic w_tx_load;
   logic w_tx_done;
   logic w_miso;

   assign w_abort   = (r_state != ST_IDLE) && ss_n;
   // tx_valid only counts after this frame's rx_valid and before the byte is taken
   assign w_tx_load = (r_state == ST_READ_DATA) && r_rx_seen && !r_tx_started
                      && tx_valid && !ss_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_shift        <= '0;
         r_bit_cnt      <= '0;
         r_rx_seen      <= 1'b0;
         r_tx_started   <= 1'b0;
         r_rd_addr_done <= 1'b0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (w_abort) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_rx_seen    <= 1'b0;
            r_tx_started <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_rx_seen    <= 1'b0;
                  r_tx_started <= 1'b0;
                  if (!ss_n) r_state <= ST_CHK_CMD;
               end
               ST_CHK_CMD: begin
                  r_shift   <= {r_shift[LP_FRAME_W-2:0], mosi};
                  r_bit_cnt <= CNT_W'(LP_FRAME_W - 1);
                  if (!mosi)               r_state <= ST_WRITE;
                  else if (r_rd_addr_done) r_state <= ST_READ_DATA;
                  else                     r_state <= ST_READ_ADD;
               end
               default: begin
                  if (r_bit_cnt != '0) begin
                     r_shift   <= {r_shift[LP_FRAME_W-2:0], mosi};
                     r_bit_cnt <= r_bit_cnt - 1'b1;
                  end else if (!r_rx_seen) begin
                     r_rx_data  <= r_shift;
                     r_rx_valid <= 1'b1;
                     r_rx_seen  <= 1'b1;
                     if (r_shift[LP_FRAME_W-1 -: 2] == CMD_RD_ADDR)
                        r_rd_addr_done <= 1'b1;
                  end
                  if (w_tx_load) r_tx_started   <= 1'b1;
                  if (w_tx_done) r_rd_addr_done <= 1'b0;
               end
            endcase
         end
      end
   end

   spi_piso_shift #(.DATA_W(DATA_W)) u_piso (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_tx_load),
      .i_clear (w_abort),
      .i_data  (tx_data),
      .o_bit   (w_miso),
      .o_done  (w_tx_done)
   );

   assign miso     = w_miso;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
SPI slave front-end controller that sequences the single-port RAM.
- Deserialises 10-bit command frames from MOSI into `rx_data`/`rx_valid` for the RAM.
- Tracks the write / read-address / read-data protocol.
- On a read-data command, captures the RAM's `tx_data`/`tx_valid` and serialises the byte back out on MISO.
- Sits between the SPI pins and the RAM in the SPI slave wrapper.

Parameters:
- `DATA_W`, 8, RAM data/address width.
- Frame width is fixed at `DATA_W+2`: 2 command bits plus payload.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `ss_n`  input  1  slave select, active low, synchronous to `clk`.
- `mosi`  input  1  serial data in, MSB first, one bit per `clk` while `ss_n`=0.
- `miso`  output  1  serial data out, registered.
- `rx_data`  output  `DATA_W+2`  assembled frame {cmd[1:0], payload}.
- `rx_valid`  output  1  one-cycle strobe: `rx_data` holds a complete frame.
- `tx_data`  input  `DATA_W`  read data from the RAM.
- `tx_valid`  input  1  `tx_data` valid strobe from the RAM.

Behaviour:
- **Reset** (`rst_n`=0, asynchronous):
  - state=IDLE.
  - `miso`=0, `rx_data`=0, `rx_valid`=0.
  - bit counter=0, `rd_addr_done`=0, tx shift register=0.
- **States:** IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Encoding is in the package.
- **ss_n=1 in any non-IDLE state:**
  - Next state=IDLE.
  - Partial frame discarded; no `rx_valid`.
  - `miso`←0.
  - `rd_addr_done` unchanged.
- **IDLE:** on `ss_n`=0 → CHK_CMD. Nothing is sampled in this cycle.
- **CHK_CMD:**
  - Sample `mosi` as frame bit 9 into the shift register.
  - `mosi`=0 → WRITE.
  - `mosi`=1 and `rd_addr_done`=0 → READ_ADD.
  - `mosi`=1 and `rd_addr_done`=1 → READ_DATA.
- **WRITE / READ_ADD / READ_DATA, receive phase:**
  - Sample frame bits 8..0 on the next 9 `clk` cycles (counter 9→1).
  - The cycle after bit 0 is sampled: `rx_data`←full frame, `rx_valid`=1 for exactly one cycle.
  - `rx_data` holds its value until the next frame completes.
- **`rd_addr_done` update** (in the `rx_valid` cycle, from the received bits):
  - cmd=2'b10 → set.
  - Cleared only when a READ_DATA transmit completes.
- **WRITE, READ_ADD:** after `rx_valid`, remain in state with `miso`=0 until `ss_n`=1.
- **READ_DATA, transmit phase:**
  - After `rx_valid`, wait for `tx_valid`=1, indefinitely while `ss_n`=0.
  - In the `tx_valid` cycle, latch `tx_data` into the tx shift register.
  - On the following `DATA_W` cycles, `miso` = tx bits MSB→LSB, one per cycle.
  - After the LSB cycle: `miso`←0, `rd_addr_done`←0, remain until `ss_n`=1.
  - `tx_valid` is ignored outside this wait window.
- **Raw pass-through:** state selection uses `mosi` bit 9 and `rd_addr_done` only; cmd bit 8 is passed to the RAM unchanged.
- **Mismatched command:** a cmd=2'b11 frame received in READ_ADD produces `rx_valid` but no MISO transfer.
- **Latency:**
  - 1 cycle IDLE→CHK_CMD.
  - 10 sampling cycles, then `rx_valid`.
  - RAM returns `tx_valid` one cycle after `rx_valid`; first MISO bit the cycle after `tx_valid`.
- **Back-to-back frames:** `ss_n` must return high for ≥1 cycle between frames. A new frame always restarts from IDLE.

Decomposition:
- Package `spi_pkg`:
  - state enum/localparams.
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - `FRAME_W`=`DATA_W+2`.
- Optional sub-module `spi_piso_shift`: `DATA_W`-bit load/shift register with done flag, used for MISO. The receive path stays inline.

Test Plan:
1. **Write address:** reset, `ss_n`=0, `mosi` bits 0,0,0,0,1,1,1,1,0,0, `ss_n`=1.
   → `rx_data`=10'h03C, `rx_valid` high exactly 1 cycle (11 cycles after `ss_n` fall), `miso`=0 throughout.
2. **Read sequence:** frame 10_0x3C → `rx_data`=10'h23C, `rd_addr_done`=1. Next frame 11_0x00, bench drives `tx_valid`=1 with `tx_data`=8'hA5 one cycle after `rx_valid`.
   → state READ_DATA; `miso` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0; `rd_addr_done`=0.
3. **Read data without address:** from reset, frame 11_0xFF.
   → state READ_ADD, `rx_data`=10'h3FF, `rx_valid` pulse, `miso` stays 0 even if `tx_valid` pulses, `rd_addr_done` stays 0.
4. **Abort:** `ss_n` raised after 5 bits of frame 01_0x55.
   → no `rx_valid`, `rx_data` retains previous value, state IDLE next cycle; a following full frame 01_0x55 yields `rx_data`=10'h155.
5. **Reset mid-transmit:** in scenario 2, assert `rst_n`=0 after the 3rd MISO bit.
   → immediately `miso`=0, `rx_valid`=0, `rd_addr_done`=0; after release, frame 11_xx enters READ_ADD.
6. **Delayed tx_valid:** in READ_DATA, `tx_valid` arrives 5 cycles after `rx_valid` with `tx_data`=8'h81.
   → `miso`=0 while waiting, then 1,0,0,0,0,0,0,1.
